// File: rtl/vga_sync_gen.sv
// VGA timing generator: a pixel-rate divider drives horizontal and vertical
// position counters; sync pulses and the visible-area flag are decoded from them.
module vga_sync_gen #(
   parameter int HD  = 640,
   parameter int HF  = 16,
   parameter int HR  = 96,
   parameter int HB  = 48,
   parameter int VD  = 480,
   parameter int VF  = 10,
   parameter int VR  = 2,
   parameter int VB  = 33,
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic       frame_tick,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y
);

   localparam int HMAX = HD + HF + HR + HB;
   localparam int VMAX = VD + VF + VR + VB;
   localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(HMAX - 1);
   localparam logic [9:0]    V_LAST   = 10'(VMAX - 1);
   localparam logic [9:0]    HS_FIRST = 10'(HD + HF);
   localparam logic [9:0]    HS_LAST  = 10'(HD + HF + HR - 1);
   localparam logic [9:0]    VS_FIRST = 10'(VD + VF);
   localparam logic [9:0]    VS_LAST  = 10'(VD + VF + VR - 1);
   localparam logic [9:0]    H_DISP   = 10'(HD);
   localparam logic [9:0]    V_DISP   = 10'(VD);

   logic [DW-1:0] div_cnt;
   logic [9:0]    x_next;
   logic [9:0]    y_next;

   assign p_tick     = (div_cnt == DIV_LAST);
   assign frame_tick = p_tick && (pix_x == H_LAST) && (pix_y == V_LAST);
   assign video_on   = (pix_x < H_DISP) && (pix_y < V_DISP);

   // Next-state position: advance one pixel per p_tick, carrying into the line count.
   always_comb begin
      x_next = pix_x;
      y_next = pix_y;
      if (p_tick) begin
         if (pix_x == H_LAST) begin
            x_next = 10'd0;
            if (pix_y == V_LAST) y_next = 10'd0;
            else                 y_next = pix_y + 10'd1;
         end else begin
            x_next = pix_x + 10'd1;
         end
      end
   end

   // Divider, counters and syncs; syncs decode the next-state counters so they
   // line up with the pix_x/pix_y values they describe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt <= '0;
         pix_x   <= 10'd0;
         pix_y   <= 10'd0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
      end else begin
         div_cnt <= p_tick ? '0 : div_cnt + DW'(1);
         pix_x   <= x_next;
         pix_y   <= y_next;
         hsync   <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
         vsync   <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
      end
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter HD, 640, horizontal display pixels.
REQ-002 Parameter HF, 16, horizontal front porch pixels.
REQ-003 Parameter HR, 96, horizontal sync pulse pixels.
REQ-004 Parameter HB, 48, horizontal back porch pixels.
REQ-005 Parameter VD, 480, vertical display lines.
REQ-006 Parameter VF, 10, vertical front porch lines.
REQ-007 Parameter VR, 2, vertical sync pulse lines.
REQ-008 Parameter VB, 33, vertical back porch lines.
REQ-009 Parameter DIV, 4, system clocks per pixel (DIV >= 2).
REQ-010 clk  input  1  system clock; all state updates on its rising edge.
REQ-011 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-012 hsync  output  1  horizontal sync, active low.
REQ-013 vsync  output  1  vertical sync, active low.
REQ-014 video_on  output  1  high while the current pixel is in the visible area.
REQ-015 p_tick  output  1  one-clk pulse per pixel period.
REQ-016 frame_tick  output  1  one-clk pulse on the last pixel of each frame.
REQ-017 pix_x  output  10  current horizontal pixel count.
REQ-018 pix_y  output  10  current vertical line count.

Function
REQ-019 HMAX = HD+HF+HR+HB (800 default) and VMAX = VD+VF+VR+VB (525 default) shall bound the counters.
REQ-020 Divider counter shall count 0..DIV-1 every clk and wrap to 0; p_tick shall be high exactly while divider == DIV-1.
REQ-021 pix_x shall increment only on a clk edge where p_tick=1, wrapping HMAX-1 -> 0.
REQ-022 pix_y shall increment only on a clk edge where p_tick=1 and pix_x == HMAX-1, wrapping VMAX-1 -> 0.
REQ-023 pix_x and pix_y shall be registered and never exceed HMAX-1 / VMAX-1.
REQ-024 hsync shall be registered from the next-state pix_x: low iff it lies in [HD+HF, HD+HF+HR-1] (656..751 default), so it stays aligned with pix_x.
REQ-025 vsync shall be registered from the next-state pix_y: low iff it lies in [VD+VF, VD+VF+VR-1] (490..491 default).
REQ-026 video_on shall be (pix_x < HD) and (pix_y < VD), decoded from the registered counters with zero added latency.
REQ-027 frame_tick shall be high iff p_tick=1, pix_x == HMAX-1 and pix_y == VMAX-1; it coincides with that p_tick.
REQ-028 A full frame shall last exactly HMAX*VMAX*DIV clk cycles (1,680,000 default).
REQ-029 Outputs shall depend only on internal state; no input other than clk/reset_n shall affect timing.

Reset
REQ-030 While reset_n=0 at a clk edge: divider=0, pix_x=0, pix_y=0, hsync=1, vsync=1.
REQ-031 Therefore during and after reset: p_tick=0, frame_tick=0, video_on=1.
REQ-032 Reset asserted mid-frame shall return all state to REQ-030 values on that edge, discarding any pending count.
REQ-033 After reset_n rises, the first p_tick shall be high on the DIV-th clk, and pix_x shall become 1 on that edge.

Verification
REQ-034 Release reset, run 8 clks -> p_tick high on clks 4 and 8 only; pix_x 0 -> 1 -> 2; video_on=1 throughout.
REQ-035 Run to pix_x=655 -> hsync=1. At pix_x=656 -> hsync=0. At pix_x=752 -> hsync=1. At pix_x 640..799 -> video_on=0.
REQ-036 Run to line end (pix_x=799, p_tick) -> next pix_x=0, pix_y increments; at pix_y 490..491 -> vsync=0, else 1.
REQ-037 Run two full frames -> frame_tick pulses exactly twice, 1,680,000 clks apart. Each pulse is one clk, with pix_x=799, pix_y=524. The next edge gives pix_x=pix_y=0.
REQ-038 Assert reset_n=0 for one clk at pix_x=700, pix_y=491 (hsync=0, vsync=0) -> the next edge gives pix_x=0, pix_y=0, hsync=1, vsync=1, divider=0.
REQ-039 Set DIV=2, HD=8, HF=2, HR=2, HB=2, VD=4, VF=1, VR=1, VB=1 -> frame is 14*7*2=196 clks; sync windows are pix_x 10..11 and pix_y 5.
